// File: rtl/mdu_pkg.sv
// Shared types and op-classification helpers for the iterative multiply/divide unit.
package mdu_pkg;

   // RV32M funct3 encoding
   typedef enum logic [2:0] {
      MUL    = 3'd0,
      MULH   = 3'd1,
      MULHSU = 3'd2,
      MULHU  = 3'd3,
      DIV    = 3'd4,
      DIVU   = 3'd5,
      REM    = 3'd6,
      REMU   = 3'd7
   } mdu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } mdu_state_t;

   function automatic logic is_div(mdu_op_t op);
      return op inside {DIV, DIVU, REM, REMU};
   endfunction

   function automatic logic is_rem(mdu_op_t op);
      return op inside {REM, REMU};
   endfunction

   function automatic logic op1_signed(mdu_op_t op);
      return op inside {MUL, MULH, MULHSU, DIV, REM};
   endfunction

   function automatic logic op2_signed(mdu_op_t op);
      return op inside {MUL, MULH, DIV, REM};
   endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// Handshake: a request is taken on a rising edge where start=1, busy=0 and flush=0;
// the requester holds start until busy rises. done is a one-cycle pulse in which
// result is valid; result then holds until the next done. There is no ready/backpressure
// on the result side.
interface mdu_if
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
);
   logic            start;
   mdu_op_t         op;
   logic [XLEN-1:0] operand1;
   logic [XLEN-1:0] operand2;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, op, operand1, operand2, flush,
      input  busy, done, result
   );

   modport slave (
      input  start, op, operand1, operand2, flush,
      output busy, done, result
   );
endinterface

// File: rtl/mdu_iter_core.sv
// Shift registers and the single XLEN+1 adder shared by the radix-2 shift-add multiplier
// and the restoring divider. Works on unsigned magnitudes; one step per enabled cycle.
// Multiply: {hi,lo} ends as the 2*XLEN product. Divide: lo = quotient, hi = remainder.
module mdu_iter_core #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            step,
   input  logic            div_mode,
   input  logic [XLEN-1:0] load_a,   // multiplier / dividend magnitude
   input  logic [XLEN-1:0] load_b,   // multiplicand / divisor magnitude
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);
   logic [XLEN-1:0] acc_q, q_q, b_q;
   logic [XLEN-1:0] acc_d, q_d;
   logic [XLEN:0]   add_a, add_b, sum;
   logic            add_ci;

   // Shared adder: acc+b for multiply, (acc<<1 | next dividend bit) - b for divide
   always_comb begin
      add_a  = div_mode ? {acc_q, q_q[XLEN-1]} : {1'b0, acc_q};
      add_b  = div_mode ? ~{1'b0, b_q} : {1'b0, b_q};
      add_ci = div_mode;
      sum    = add_a + add_b + {{XLEN{1'b0}}, add_ci};
   end

   // Next step: shift-add right for multiply, subtract-or-restore left for divide
   always_comb begin
      acc_d = acc_q;
      q_d   = q_q;
      if (div_mode) begin
         if (!sum[XLEN]) begin
            acc_d = sum[XLEN-1:0];
            q_d   = {q_q[XLEN-2:0], 1'b1};
         end else begin
            acc_d = add_a[XLEN-1:0];
            q_d   = {q_q[XLEN-2:0], 1'b0};
         end
      end else if (q_q[0]) begin
         acc_d = sum[XLEN:1];
         q_d   = {sum[0], q_q[XLEN-1:1]};
      end else begin
         acc_d = add_a[XLEN:1];
         q_d   = {add_a[0], q_q[XLEN-1:1]};
      end
   end

   // Datapath registers: load on acceptance, advance one step when enabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         q_q   <= '0;
         b_q   <= '0;
      end else if (load) begin
         acc_q <= '0;
         q_q   <= load_a;
         b_q   <= load_b;
      end else if (step) begin
         acc_q <= acc_d;
         q_q   <= q_d;
      end
   end

   assign hi = acc_q;
   assign lo = q_q;

endmodule

// File: rtl/mdu_seq.sv
// Sequencing FSM for the iterative RV32M multiply/divide unit: operand sign handling,
// divide special cases, final sign fix-up and word select. Arithmetic lives in mdu_iter_core.
module mdu_seq
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   mdu_if.slave       bus,
   output mdu_state_t dbg_state
);
   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   mdu_state_t      state_q, state_d;
   logic [CW-1:0]   cnt_q;
   mdu_op_t         op_q;
   logic            neg_q, spec_q;
   logic [XLEN-1:0] spec_res_q, result_q;

   logic            accept, s1, s2, special;
   logic [XLEN-1:0] mag1, mag2, spec_val, fix_val;
   logic [XLEN-1:0] core_hi, core_lo, div_raw, div_fix;
   logic [2*XLEN-1:0] prod, prod_fix;

   // Request decode: magnitudes, signs and the divides that skip iteration
   always_comb begin
      accept   = (state_q == IDLE) && bus.start && !bus.flush;
      s1       = op1_signed(bus.op) && bus.operand1[XLEN-1];
      s2       = op2_signed(bus.op) && bus.operand2[XLEN-1];
      mag1     = s1 ? -bus.operand1 : bus.operand1;
      mag2     = s2 ? -bus.operand2 : bus.operand2;
      special  = is_div(bus.op) &&
                 ((bus.operand2 == '0) ||
                  (op1_signed(bus.op) && (bus.operand1 == MIN_NEG) && (bus.operand2 == '1)));
      spec_val = (bus.operand2 == '0) ? (is_rem(bus.op) ? bus.operand1 : '1)
                                      : (is_rem(bus.op) ? '0 : MIN_NEG);
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next state; flush overrides everything
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = special ? FIX : CALC;
         CALC:    if (cnt_q == '0) state_d = FIX;
         FIX:     state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.flush) state_d = IDLE;
   end

   // Per-operation control registers captured at acceptance, plus iteration counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q       <= MUL;
         neg_q      <= 1'b0;
         spec_q     <= 1'b0;
         spec_res_q <= '0;
         cnt_q      <= '0;
      end else if (accept) begin
         op_q       <= bus.op;
         neg_q      <= is_rem(bus.op) ? s1 : (s1 ^ s2);
         spec_q     <= special;
         spec_res_q <= spec_val;
         cnt_q      <= CW'(XLEN - 1);
      end else if ((state_q == CALC) && (cnt_q != '0)) begin
         cnt_q      <= cnt_q - 1'b1;
      end
   end

   mdu_iter_core #(.XLEN(XLEN)) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .step     (state_q == CALC),
      .div_mode (is_div(op_q)),
      .load_a   (mag1),
      .load_b   (mag2),
      .hi       (core_hi),
      .lo       (core_lo)
   );

   // Sign fix-up and word select, evaluated during FIX
   always_comb begin
      prod     = {core_hi, core_lo};
      prod_fix = neg_q ? -prod : prod;
      div_raw  = is_rem(op_q) ? core_hi : core_lo;
      div_fix  = neg_q ? -div_raw : div_raw;
      if (spec_q)                fix_val = spec_res_q;
      else if (is_div(op_q))     fix_val = div_fix;
      else if (op_q == MUL)      fix_val = prod_fix[XLEN-1:0];
      else                       fix_val = prod_fix[2*XLEN-1:XLEN];
   end

   // Result register: updated only on a completed FIX, held otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             result_q <= '0;
      else if ((state_q == FIX) && !bus.flush) result_q <= fix_val;
   end

   assign bus.busy   = (state_q != IDLE);
   assign bus.done   = (state_q == DONE);
   assign bus.result = result_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed RV32M cases, divide special cases,
// flush/reset aborts, ignored requests and a random sweep against a 64-bit reference.
module tb_mdu_seq;
   import mdu_pkg::*;

   localparam int XLEN = 32;
   localparam logic [31:0] MIN_NEG = 32'h8000_0000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   mdu_state_t dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   logic [XLEN-1:0] exp_q[$];
   logic [XLEN-1:0] last_res = '0;

   mdu_if #(.XLEN(XLEN)) bus ();

   mdu_seq #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   // reference model built on 64-bit native arithmetic
   function automatic logic [31:0] ref_model(mdu_op_t op, logic [31:0] a, logic [31:0] b);
      longint sa, sb, ub, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'b0, b});
      case (op)
         MUL:    begin r = sa * sb; p = r; return p[31:0]; end
         MULH:   begin r = sa * sb; p = r; return p[63:32]; end
         MULHSU: begin r = sa * ub; p = r; return p[63:32]; end
         MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         DIV:    begin if (b == 0) return 32'hFFFF_FFFF; r = sa / sb; return r[31:0]; end
         DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         REM:    begin if (b == 0) return a; r = sa % sb; return r[31:0]; end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_latency(mdu_op_t op, logic [31:0] a, logic [31:0] b);
      if ((op inside {DIV, DIVU, REM, REMU}) && (b == 0)) return 2;
      if ((op inside {DIV, REM}) && (a == MIN_NEG) && (b == 32'hFFFF_FFFF)) return 2;
      return 34;
   endfunction

   // driver: present one request, push its expected result, drop start after acceptance
   task automatic drive_op(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
      int w;
      w = 0;
      while (bus.busy && w < 200) begin @(negedge clk); w++; end
      @(negedge clk);
      bus.op = op; bus.operand1 = a; bus.operand2 = b; bus.start = 1'b1;
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.operand1 = $urandom;
      bus.operand2 = $urandom;
      bus.op = mdu_op_t'($urandom_range(0, 7));
   endtask

   // monitor: bounded wait for done; reports cycles counted from the acceptance edge
   task automatic wait_done(output logic got, output int cyc, output logic [31:0] res,
                            output logic busy_after);
      got = 1'b0; cyc = 0; res = '0; busy_after = 1'b1;
      while (!got && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (bus.done) begin got = 1'b1; res = bus.result; end
      end
      if (got) begin
         @(negedge clk);
         busy_after = bus.busy | bus.done;
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.flush = 1'b0; bus.op = MUL; bus.operand1 = '0; bus.operand2 = '0;
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
      n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.result); end
      n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      last_res = '0;
   endtask

   task automatic test_mul();
      mdu_op_t     ops[4] = '{MUL, MULHU, MULH, MULHSU};
      logic [31:0] av[4]  = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] bv[4]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
      logic [31:0] ev[4]  = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF};
      logic got, ba; int cyc; logic [31:0] res, exp;
      for (int i = 0; i < 4; i++) begin
         drive_op(ops[i], av[i], bv[i], ev[i]);
         wait_done(got, cyc, res, ba);
         n_checks++;
         if (!got) begin
            n_fail++; $display("FAIL mul_timeout[%0d]: no done within %0d cycles", i, cyc);
            exp_q.delete();
         end else begin
            exp = exp_q.pop_front();
            if (res !== exp) begin n_fail++; $display("FAIL mul_result[%0d]: got %h want %h", i, res, exp); end
            n_checks++; if (cyc != 34) begin n_fail++; $display("FAIL mul_latency[%0d]: got %0d want 34", i, cyc); end
            n_checks++; if (ba !== 1'b0) begin n_fail++; $display("FAIL mul_idle_after[%0d]: got %b want 0", i, ba); end
            last_res = exp;
         end
      end
   endtask

   task automatic test_div();
      mdu_op_t     ops[8] = '{DIV, REM, DIVU, REMU, DIVU, REM, DIV, REM};
      logic [31:0] av[8]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, MIN_NEG, MIN_NEG};
      logic [31:0] bv[8]  = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] ev[8]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, MIN_NEG, 32'd0};
      int          lv[8]  = '{34, 34, 34, 34, 2, 2, 2, 2};
      logic got, ba; int cyc; logic [31:0] res, exp;
      for (int i = 0; i < 8; i++) begin
         drive_op(ops[i], av[i], bv[i], ev[i]);
         wait_done(got, cyc, res, ba);
         n_checks++;
         if (!got) begin
            n_fail++; $display("FAIL div_timeout[%0d]: no done within %0d cycles", i, cyc);
            exp_q.delete();
         end else begin
            exp = exp_q.pop_front();
            if (res !== exp) begin n_fail++; $display("FAIL div_result[%0d]: got %h want %h", i, res, exp); end
            n_checks++; if (cyc != lv[i]) begin n_fail++; $display("FAIL div_latency[%0d]: got %0d want %0d", i, cyc, lv[i]); end
            last_res = exp;
         end
      end
   endtask

   task automatic test_flush();
      logic seen; logic got, ba; int cyc; logic [31:0] res, exp;
      drive_op(MUL, 32'd123, 32'd456, 32'd56088);
      repeat (9) @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk);
      #1 bus.flush = 1'b0;
      exp_q.delete();
      @(negedge clk);
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", bus.busy); end
      seen = 1'b0;
      repeat (40) begin @(negedge clk); if (bus.done) seen = 1'b1; end
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_done: got done=%b want 0", seen); end
      n_checks++; if (bus.result !== last_res) begin n_fail++; $display("FAIL flush_result_held: got %h want %h", bus.result, last_res); end
      drive_op(MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E);
      wait_done(got, cyc, res, ba);
      n_checks++;
      if (!got) begin
         n_fail++; $display("FAIL flush_restart_timeout: no done within %0d cycles", cyc);
         exp_q.delete();
      end else begin
         exp = exp_q.pop_front();
         if (res !== exp) begin n_fail++; $display("FAIL flush_restart_result: got %h want %h", res, exp); end
         n_checks++; if (cyc != 34) begin n_fail++; $display("FAIL flush_restart_latency: got %0d want 34", cyc); end
         last_res = exp;
      end
   endtask

   task automatic test_ignore();
      logic seen; logic got, ba; int cyc; logic [31:0] res, exp;
      drive_op(DIVU, 32'd1000, 32'd9, 32'd111);
      repeat (4) @(negedge clk);
      bus.op = MUL; bus.operand1 = 32'd3; bus.operand2 = 32'd3; bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL ignore_busy_held: got %b want 1", bus.busy); end
      wait_done(got, cyc, res, ba);
      n_checks++;
      if (!got) begin
         n_fail++; $display("FAIL ignore_timeout: no done within %0d cycles", cyc);
         exp_q.delete();
      end else begin
         exp = exp_q.pop_front();
         if (res !== exp) begin n_fail++; $display("FAIL ignore_result: got %h want %h", res, exp); end
         last_res = exp;
      end
      seen = 1'b0;
      repeat (40) begin @(negedge clk); if (bus.done) seen = 1'b1; end
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL ignore_no_second_op: got done=%b want 0", seen); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_idle: got busy=%b want 0", bus.busy); end
      // flush and start together in IDLE
      @(negedge clk);
      bus.op = MUL; bus.operand1 = 32'd5; bus.operand2 = 32'd5; bus.start = 1'b1; bus.flush = 1'b1;
      @(posedge clk);
      #1 begin bus.start = 1'b0; bus.flush = 1'b0; end
      @(negedge clk);
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy: got %b want 0", bus.busy); end
      seen = 1'b0;
      repeat (40) begin @(negedge clk); if (bus.done) seen = 1'b1; end
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_start_no_done: got done=%b want 0", seen); end
      n_checks++; if (bus.result !== last_res) begin n_fail++; $display("FAIL flush_start_result: got %h want %h", bus.result, last_res); end
   endtask

   task automatic test_reset_mid();
      logic got, ba; int cyc; logic [31:0] res, exp;
      drive_op(DIV, 32'd77777, 32'd13, 32'd5982);
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", bus.done); end
      n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL rstmid_result: got %h want 0", bus.result); end
      @(negedge clk);
      rst_n = 1'b1;
      last_res = '0;
      drive_op(REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
      wait_done(got, cyc, res, ba);
      n_checks++;
      if (!got) begin
         n_fail++; $display("FAIL rstmid_restart_timeout: no done within %0d cycles", cyc);
         exp_q.delete();
      end else begin
         exp = exp_q.pop_front();
         if (res !== exp) begin n_fail++; $display("FAIL rstmid_restart_result: got %h want %h", res, exp); end
         n_checks++; if (cyc != 34) begin n_fail++; $display("FAIL rstmid_restart_latency: got %0d want 34", cyc); end
         last_res = exp;
      end
   endtask

   task automatic test_random();
      mdu_op_t op; logic [31:0] a, b, exp; int lat;
      logic got, ba; int cyc; logic [31:0] res;
      for (int i = 0; i < 40; i++) begin
         op = mdu_op_t'($urandom_range(0, 7));
         case ($urandom_range(0, 5))
            0:       a = 32'h0;
            1:       a = MIN_NEG;
            2:       a = 32'hFFFF_FFFF;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0:       b = 32'h0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = $urandom_range(1, 15);
            default: b = $urandom;
         endcase
         lat = exp_latency(op, a, b);
         drive_op(op, a, b, ref_model(op, a, b));
         wait_done(got, cyc, res, ba);
         n_checks++;
         if (!got) begin
            n_fail++; $display("FAIL rand_timeout[%0d]: op %0d no done within %0d cycles", i, op, cyc);
            exp_q.delete();
         end else begin
            exp = exp_q.pop_front();
            if (res !== exp) begin
               n_fail++; $display("FAIL rand_result[%0d]: op %0d a %h b %h got %h want %h", i, op, a, b, res, exp);
            end
            n_checks++; if (cyc != lat) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, cyc, lat); end
            n_checks++; if (ba !== 1'b0) begin n_fail++; $display("FAIL rand_idle_after[%0d]: got %b want 0", i, ba); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_flush();
      test_ignore();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
